// File: rtl/softmax_avg_argmax_if.sv
// Shared intermediate-result memory port used by softmax_avg_argmax.
// master drives requests and write data; slave returns read data.
interface softmax_avg_argmax_if;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [14:0] mem_wr_data;
    logic [14:0] mem_rd_data;

    modport master (
        output mem_rd_en,
        output mem_wr_en,
        output mem_addr,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_addr,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/softmax_avg_argmax.sv
// Softmax history averaging, argmax sleep-stage selection and history retire.
// Optional SOFTMAX_AVG_WARMUP_EN limits history reads until two runs have completed.
module softmax_avg_argmax #(
    parameter int unsigned MEM_RD_LATENCY = 2,
    parameter int unsigned CUR_BASE       = 32,
    parameter int unsigned AVG_BASE       = 0,
    parameter int unsigned PREV_BASE      = 57334
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  sleep_stage,
    softmax_avg_argmax_if.master        mem
);
    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StRdReq  = 4'd1;
    localparam logic [3:0] StRdWait = 4'd2;
    localparam logic [3:0] StAvg    = 4'd3;
    localparam logic [3:0] StWrAvg  = 4'd4;
    localparam logic [3:0] StRtRd0  = 4'd5;
    localparam logic [3:0] StRtWait = 4'd6;
    localparam logic [3:0] StRtWr1  = 4'd7;
    localparam logic [3:0] StRtRdc  = 4'd8;
    localparam logic [3:0] StRtWr0  = 4'd9;
    localparam logic [3:0] StDone   = 4'd10;

    localparam logic [15:0] CurBase   = 16'(CUR_BASE);
    localparam logic [15:0] AvgBase   = 16'(AVG_BASE);
    localparam logic [15:0] PrevBase  = 16'(PREV_BASE);
    localparam logic [15:0] Prev1Base = 16'(PREV_BASE + 5);
    localparam logic [7:0]  WaitLast  = 8'(MEM_RD_LATENCY - 1);
    localparam logic [16:0] RecipThird = 17'd21846;

    logic [3:0]         state_q, state_d;
    logic [2:0]         cls_q, cls_d;
    logic [1:0]         rd_idx_q, rd_idx_d;
    logic [7:0]         wait_q, wait_d;
    logic               rt_ph_q, rt_ph_d;
    logic signed [16:0] sum_q, sum_d;
    logic signed [14:0] avg_q, avg_d;
    logic signed [14:0] hold_q, hold_d;
    logic signed [14:0] best_val_q, best_val_d;
    logic [2:0]         best_idx_q, best_idx_d;
    logic [2:0]         stage_q, stage_d;

    logic [1:0]         last_idx;
    logic [16:0]        recip;
    logic signed [34:0] prod;
    logic signed [14:0] avg_new;
    logic [15:0]        cls_ext;
    logic               unused_prod;

`ifdef SOFTMAX_AVG_WARMUP_EN
    logic [1:0] valid_cnt_q, valid_cnt_d;

    always_comb begin
        last_idx    = valid_cnt_q;
        valid_cnt_d = valid_cnt_q;
        unique case (valid_cnt_q)
            2'd0:    recip = 17'd65536;
            2'd1:    recip = 17'd32768;
            default: recip = RecipThird;
        endcase
        if (state_q == StDone && valid_cnt_q != 2'd2) valid_cnt_d = valid_cnt_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_cnt_q <= 2'd0;
        else     valid_cnt_q <= valid_cnt_d;
    end
`else
    assign last_idx = 2'd2;
    assign recip    = RecipThird;
`endif

    // Floor of sum*R/65536; only bits [30:16] matter for a 15-bit average.
    assign prod        = $signed({{18{sum_q[16]}}, sum_q}) * $signed({18'd0, recip});
    assign avg_new     = prod[30:16];
    assign unused_prod = ^{prod[34:31], prod[15:0]};
    assign cls_ext     = {13'd0, cls_q};

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        rd_idx_d   = rd_idx_q;
        wait_d     = wait_q;
        rt_ph_d    = rt_ph_q;
        sum_d      = sum_q;
        avg_d      = avg_q;
        hold_d     = hold_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        stage_d    = stage_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRdReq;
                    cls_d    = 3'd0;
                    rd_idx_d = 2'd0;
                    sum_d    = '0;
                end
            end
            StRdReq: begin
                state_d = StRdWait;
                wait_d  = 8'd0;
            end
            StRdWait: begin
                if (wait_q == WaitLast) begin
                    sum_d = sum_q + $signed({{2{mem.mem_rd_data[14]}}, mem.mem_rd_data});
                    if (rd_idx_q == last_idx) begin
                        state_d = StAvg;
                    end else begin
                        rd_idx_d = rd_idx_q + 2'd1;
                        state_d  = StRdReq;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StAvg: begin
                avg_d   = avg_new;
                state_d = StWrAvg;
                // Strictly greater keeps the lowest index on ties.
                if (cls_q == 3'd0 || avg_new > best_val_q) begin
                    best_val_d = avg_new;
                    best_idx_d = cls_q;
                end
            end
            StWrAvg: begin
                rd_idx_d = 2'd0;
                sum_d    = '0;
                if (cls_q == 3'd4) begin
                    cls_d   = 3'd0;
                    state_d = StRtRd0;
                end else begin
                    cls_d   = cls_q + 3'd1;
                    state_d = StRdReq;
                end
            end
            StRtRd0: begin
                state_d = StRtWait;
                wait_d  = 8'd0;
                rt_ph_d = 1'b0;
            end
            StRtWait: begin
                if (wait_q == WaitLast) begin
                    hold_d  = mem.mem_rd_data;
                    state_d = rt_ph_q ? StRtWr0 : StRtWr1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StRtWr1: state_d = StRtRdc;
            StRtRdc: begin
                state_d = StRtWait;
                wait_d  = 8'd0;
                rt_ph_d = 1'b1;
            end
            StRtWr0: begin
                if (cls_q == 3'd4) begin
                    state_d = StDone;
                    stage_d = best_idx_q;
                end else begin
                    cls_d   = cls_q + 3'd1;
                    state_d = StRtRd0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cls_q      <= 3'd0;
            rd_idx_q   <= 2'd0;
            wait_q     <= 8'd0;
            rt_ph_q    <= 1'b0;
            sum_q      <= '0;
            avg_q      <= '0;
            hold_q     <= '0;
            best_val_q <= '0;
            best_idx_q <= 3'd0;
            stage_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            rd_idx_q   <= rd_idx_d;
            wait_q     <= wait_d;
            rt_ph_q    <= rt_ph_d;
            sum_q      <= sum_d;
            avg_q      <= avg_d;
            hold_q     <= hold_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            stage_q    <= stage_d;
        end
    end

    always_comb begin
        mem.mem_rd_en   = 1'b0;
        mem.mem_wr_en   = 1'b0;
        mem.mem_addr    = 16'd0;
        mem.mem_wr_data = 15'd0;
        unique case (state_q)
            StRdReq: begin
                mem.mem_rd_en = 1'b1;
                if (rd_idx_q == 2'd0)      mem.mem_addr = CurBase + cls_ext;
                else if (rd_idx_q == 2'd1) mem.mem_addr = PrevBase + cls_ext;
                else                       mem.mem_addr = Prev1Base + cls_ext;
            end
            StWrAvg: begin
                mem.mem_wr_en   = 1'b1;
                mem.mem_addr    = AvgBase + cls_ext;
                mem.mem_wr_data = avg_q;
            end
            StRtRd0: begin
                mem.mem_rd_en = 1'b1;
                mem.mem_addr  = PrevBase + cls_ext;
            end
            StRtWr1: begin
                mem.mem_wr_en   = 1'b1;
                mem.mem_addr    = Prev1Base + cls_ext;
                mem.mem_wr_data = hold_q;
            end
            StRtRdc: begin
                mem.mem_rd_en = 1'b1;
                mem.mem_addr  = CurBase + cls_ext;
            end
            StRtWr0: begin
                mem.mem_wr_en   = 1'b1;
                mem.mem_addr    = PrevBase + cls_ext;
                mem.mem_wr_data = hold_q;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign sleep_stage = stage_q;
endmodule

// File: tb/tb_softmax_avg_argmax.sv
// Directed bench for softmax_avg_argmax with a latency-2 memory model and a write scoreboard.
module tb_softmax_avg_argmax;
    localparam int L    = 2;
    localparam int CUR  = 32;
    localparam int AVG  = 0;
    localparam int PREV = 57334;

    typedef struct packed {
        logic [15:0] a;
        logic [14:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] sleep_stage;

    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'd0;
    logic [14:0] ld_data = 15'd0;
    logic [14:0] mem_arr [0:65535];
    logic [15:0] rd_a1;
    logic        rd_v1;
    logic        port_bad = 1'b0;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t exp_q[$];

    softmax_avg_argmax_if mem_if ();

    softmax_avg_argmax #(
        .MEM_RD_LATENCY(L),
        .CUR_BASE      (CUR),
        .AVG_BASE      (AVG),
        .PREV_BASE     (PREV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .sleep_stage(sleep_stage),
        .mem        (mem_if)
    );

    always #5 clk = ~clk;

    // Memory model: data for a request in cycle t is valid during cycle t+2.
    always @(posedge clk) begin
        rd_a1 <= mem_if.mem_addr;
        rd_v1 <= mem_if.mem_rd_en;
        if (rd_v1) mem_if.mem_rd_data <= mem_arr[rd_a1];
        if (ld_en) mem_arr[ld_addr] <= ld_data;
        else if (mem_if.mem_wr_en) mem_arr[mem_if.mem_addr] <= mem_if.mem_wr_data;
    end

    function automatic bit addr_ok(input logic [15:0] a);
        return (a <= 16'd4) || (a >= 16'd32 && a <= 16'd36) ||
               (a >= 16'd57334 && a <= 16'd57343);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            if (mem_if.mem_rd_en && mem_if.mem_wr_en) port_bad <= 1'b1;
            if ((mem_if.mem_rd_en || mem_if.mem_wr_en) && !addr_ok(mem_if.mem_addr))
                port_bad <= 1'b1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int addr, input int val);
        ld_addr = 16'(addr);
        ld_data = 15'(val);
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic load5(input int base, input int v0, input int v1, input int v2,
                         input int v3, input int v4);
        load(base, v0);
        load(base + 1, v1);
        load(base + 2, v2);
        load(base + 3, v3);
        load(base + 4, v4);
    endtask

    task automatic push5(input int v0, input int v1, input int v2, input int v3, input int v4);
        int v [5];
        v = '{v0, v1, v2, v3, v4};
        for (int i = 0; i < 5; i++) exp_q.push_back('{a: 16'(AVG + i), d: 15'(v[i])});
    endtask

    // Start in cycle 0 (called at a negedge); optional second start at cycle restart_at.
    task automatic run(input string name, input int exp_cyc, input int exp_stage,
                       input int restart_at);
        int  cyc;
        bit  seen;
        wr_t e;
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (cyc == 1) begin
                check({name, "_first_rd_en"}, int'(mem_if.mem_rd_en), 1);
                check({name, "_first_addr"}, int'(mem_if.mem_addr), CUR);
                check({name, "_busy"}, int'(busy), 1);
            end
            if (mem_if.mem_wr_en && mem_if.mem_addr < 16'd5) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra_avg_wr"}, int'(mem_if.mem_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s_avg_addr", name), int'(mem_if.mem_addr), int'(e.a));
                    check($sformatf("%s_avg%0d", name, e.a), int'(mem_if.mem_wr_data),
                          int'(e.d));
                end
            end
            if (done) begin
                seen = 1'b1;
                check({name, "_done_cycle"}, cyc, exp_cyc);
                check({name, "_sleep_stage"}, int'(sleep_stage), exp_stage);
                check({name, "_busy_at_done"}, int'(busy), 1);
            end
        end
        start = 1'b0;
        check({name, "_done_seen"}, int'(seen), 1);
        check({name, "_avg_left"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_stage_held"}, int'(sleep_stage), exp_stage);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_stage", int'(sleep_stage), 0);
        check("rst_rd_en", int'(mem_if.mem_rd_en), 0);
        check("rst_wr_en", int'(mem_if.mem_wr_en), 0);
        check("rst_addr", int'(mem_if.mem_addr), 0);
        check("rst_wr_data", int'(mem_if.mem_wr_data), 0);
        rst = 1'b0;
        @(negedge clk);

`ifndef SOFTMAX_AVG_WARMUP_EN
        load5(CUR, 300, 600, 0, 0, 0);
        load5(PREV, 0, 0, 900, 0, 0);
        load5(PREV + 5, 0, 0, 0, 0, 0);
        push5(100, 200, 300, 0, 0);
        run("basic", 96, 2, -1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("basic_slot1_%0d", c), int'(mem_arr[PREV + 5 + c]),
                  (c == 2) ? 900 : 0);
            check($sformatf("basic_slot0_%0d", c), int'(mem_arr[PREV + c]),
                  (c == 0) ? 300 : (c == 1) ? 600 : 0);
        end

        // Reset mid-run: rst high in cycle 50, idle outputs in cycle 51.
        start = 1'b1;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_stage", int'(sleep_stage), 0);
        check("midrst_rd_en", int'(mem_if.mem_rd_en), 0);
        check("midrst_wr_en", int'(mem_if.mem_wr_en), 0);
        rst = 1'b0;
        @(negedge clk);
        // History now: slot0 = cur = [300,600,0,0,0], slot1 = [0,0,900,0,0].
        push5(200, 400, 300, 0, 0);
        run("after_rst", 96, 1, -1);

        load5(CUR, 30, 30, 30, 30, 30);
        load5(PREV, 0, 0, 0, 0, 0);
        load5(PREV + 5, 0, 0, 0, 0, 0);
        push5(10, 10, 10, 10, 10);
        run("tie_restart", 96, 0, 40);
        check("tie_idle_rd_en", int'(mem_if.mem_rd_en), 0);
`else
        load5(CUR, 0, 0, 0, 0, 1000);
        load5(PREV, 9, 9, 9, 9, 9);
        load5(PREV + 5, 7, 7, 7, 7, 7);
        push5(0, 0, 0, 0, 1000);
        run("warm0", 66, 4, -1);
        check("warm0_slot0_4", int'(mem_arr[PREV + 4]), 1000);
        check("warm0_slot1_4", int'(mem_arr[PREV + 9]), 9);
        load5(CUR, 200, 0, 0, 0, 500);
        push5(100, 0, 0, 0, 750);
        run("warm1", 81, 4, -1);
        check("warm1_slot1_4", int'(mem_arr[PREV + 9]), 1000);
        check("warm1_slot0_0", int'(mem_arr[PREV]), 200);
`endif

        check("port_rules", int'(port_bad), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
